// File: rtl/riscv_alu_div_serial.sv
// Serial radix-2 restoring divider for the EX stage (DIVU/DIV/REMU/REM).
// One quotient bit per cycle; results return through a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for operands, op_ready_o high
// DIV   | WIDTH restoring iterations in progress
// DONE  | result_o valid, waiting for result_ready_i
module riscv_alu_div_serial #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [1:0]       operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] b_mag_q;
    logic             op_rem_q;
    logic             neg_q_q;
    logic             neg_r_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             ovf;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] res_final;

    always_comb begin
        a_neg  = operator_i[0] & op_a_i[WIDTH-1];
        b_neg  = operator_i[0] & op_b_i[WIDTH-1];
        a_mag  = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        b_mag  = b_neg ? (~op_b_i + 1'b1) : op_b_i;
        b_zero = (op_b_i == '0);
        ovf    = operator_i[0] & (op_a_i == MIN_NEG) & (op_b_i == '1);
    end

    // rem_sh < 2*|b|, so bit WIDTH of the trial difference is exactly the borrow.
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, b_mag_q};
        borrow  = trial[WIDTH];
        rem_nxt = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], ~borrow};
        if (op_rem_q) begin
            res_final = neg_r_q ? (~rem_nxt + 1'b1) : rem_nxt;
        end else begin
            res_final = neg_q_q ? (~quo_nxt + 1'b1) : quo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_ready_o     <= 1'b1;
            result_valid_o <= 1'b0;
            result_o       <= '0;
            cnt            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            b_mag_q        <= '0;
            op_rem_q       <= 1'b0;
            neg_q_q        <= 1'b0;
            neg_r_q        <= 1'b0;
        end else if (flush_i) begin
            state          <= IDLE;
            op_ready_o     <= 1'b1;
            result_valid_o <= 1'b0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid_i) begin
                        op_ready_o <= 1'b0;
                        op_rem_q   <= operator_i[1];
                        neg_q_q    <= operator_i[0] & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]) & ~b_zero;
                        neg_r_q    <= a_neg;
                        if (b_zero) begin
                            result_o       <= operator_i[1] ? op_a_i : '1;
                            result_valid_o <= 1'b1;
                            state          <= DONE;
                        end else if (ovf) begin
                            result_o       <= operator_i[1] ? '0 : MIN_NEG;
                            result_valid_o <= 1'b1;
                            state          <= DONE;
                        end else begin
                            cnt     <= CNT_W'(WIDTH - 1);
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            b_mag_q <= b_mag;
                            state   <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_o       <= res_final;
                        result_valid_o <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        op_ready_o     <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    op_ready_o     <= 1'b1;
                    result_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_alu_div_serial.sv
// Directed bench for riscv_alu_div_serial: results, latency, handshake hold,
// flush and reset behaviour with hand-computed expectations.
module tb_riscv_alu_div_serial;

    localparam logic [1:0] OP_DIVU = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  operator;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    riscv_alu_div_serial #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .op_valid_i     (op_valid),
        .op_ready_o     (op_ready),
        .operator_i     (operator),
        .op_a_i         (op_a),
        .op_b_i         (op_b),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .result_o       (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_n,
                          input bit rdy);
        int n;
        op_valid     = 1'b1;
        operator     = op;
        op_a         = a;
        op_b         = b;
        result_ready = rdy;
        step();
        op_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        operator = 2'($urandom_range(0, 3));
        n = 1;
        while (!result_valid && n < 100) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
        check(tag, result, exp);
        if (rdy) begin
            step();
            check({tag, "_idle"}, {30'd0, op_ready, result_valid}, 32'd2);
        end
    endtask

    initial begin
        int vcount;
        rst          = 1'b1;
        flush        = 1'b0;
        op_valid     = 1'b0;
        operator     = OP_DIVU;
        op_a         = '0;
        op_b         = '0;
        result_ready = 1'b1;
        step();
        step();
        check("rst_ready", {31'd0, op_ready}, 32'd1);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        step();

        run_op("divu_20_3", OP_DIVU, 32'd20, 32'd3, 32'd6, 33, 1'b1);
        run_op("remu_20_3", OP_REMU, 32'd20, 32'd3, 32'd2, 33, 1'b1);
        run_op("div_m20_3", OP_DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33, 1'b1);
        run_op("rem_m20_3", OP_REM, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33, 1'b1);
        run_op("rem_20_m3", OP_REM, 32'd20, 32'hFFFFFFFD, 32'd2, 33, 1'b1);
        run_op("div_20_m3", OP_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33, 1'b1);
        run_op("divu_7_0", OP_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 1, 1'b1);
        run_op("remu_7_0", OP_REMU, 32'd7, 32'd0, 32'd7, 1, 1'b1);
        run_op("div_m7_0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1, 1'b1);
        run_op("rem_m7_0", OP_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1, 1'b1);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b1);
        run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b1);
        run_op("divu_min_m1", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 1'b1);
        run_op("divu_0_5", OP_DIVU, 32'd0, 32'd5, 32'd0, 33, 1'b1);
        run_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 1'b1);
        run_op("div_min_2", OP_DIV, 32'h80000000, 32'd2, 32'hC0000000, 33, 1'b1);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);

        // Hold in DONE with a competing request that must not be taken.
        run_op("hold_res", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        op_valid = 1'b1;
        operator = OP_DIVU;
        op_a     = 32'd9;
        op_b     = 32'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_stable", result, 32'd14);
            check("hold_flags", {30'd0, op_ready, result_valid}, 32'd1);
        end
        result_ready = 1'b1;
        step();
        op_valid = 1'b0;
        check("hold_release", {30'd0, op_ready, result_valid}, 32'd2);
        step();
        step();
        check("hold_no_accept", {30'd0, op_ready, result_valid}, 32'd2);

        // Flush at DIV cycle 15 with op_valid also high.
        op_valid = 1'b1;
        operator = OP_DIVU;
        op_a     = 32'd1000;
        op_b     = 32'd7;
        step();
        op_valid = 1'b0;
        for (int i = 1; i < 15; i++) step();
        flush    = 1'b1;
        op_valid = 1'b1;
        step();
        flush    = 1'b0;
        op_valid = 1'b0;
        check("flush_idle", {30'd0, op_ready, result_valid}, 32'd2);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (result_valid) vcount++;
        end
        check("flush_no_result", 32'(vcount), 32'd0);
        run_op("post_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);

        // Flush discards a pending result in DONE.
        run_op("flush_done_pre", OP_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        flush = 1'b1;
        step();
        flush        = 1'b0;
        result_ready = 1'b1;
        check("flush_done", {30'd0, op_ready, result_valid}, 32'd2);

        // Reset mid-DIV.
        op_valid = 1'b1;
        operator = OP_DIVU;
        op_a     = 32'd1000;
        op_b     = 32'd7;
        step();
        op_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("pre_rst_busy", {31'd0, op_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_flags", {30'd0, op_ready, result_valid}, 32'd2);
        check("mid_rst_result", result, 32'd0);
        run_op("post_rst", OP_REM, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
